// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 32x32 register file: WB vs. MDU with starvation
// protection, a registered write stage and a pending-destination scoreboard.
module regfile_wr_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_valid_i,
  output logic        wb_ready_o,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        mdu_valid_i,
  output logic        mdu_ready_o,
  input  logic [4:0]  mdu_rd_i,
  input  logic [31:0] mdu_data_i,
  input  logic        mdu_issue_i,
  input  logic [4:0]  mdu_issue_rd_i,
  output logic        mdu_issue_ready_o,
  input  logic [4:0]  q_rs1_i,
  input  logic [4:0]  q_rs2_i,
  input  logic [4:0]  q_rd_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  output logic        rd_busy_o,
  output logic        w_ena_o,
  output logic [4:0]  w_address_o,
  output logic [31:0] w_data_o
);

  logic [3:0]  starve_cnt_reg;
  logic [3:0]  starve_cnt_next;
  logic        mdu_prio;
  logic        w_ena_reg;
  logic [4:0]  w_address_reg;
  logic [31:0] w_data_reg;
  logic        w_from_mdu_reg;
  logic [31:0] pending_reg;
  logic [31:0] pending_next;
  logic        issue_set;
  logic        mdu_retire;

  assign mdu_prio    = (starve_cnt_reg >= 4'(STARVE_MAX));
  assign wb_ready_o  = wb_valid_i && (!mdu_prio || !mdu_valid_i);
  assign mdu_ready_o = mdu_valid_i && (!wb_valid_i || mdu_prio);

  // Counts consecutive denied MDU cycles; any idle or granted cycle restarts it.
  always_comb begin
    starve_cnt_next = 4'd0;
    if (mdu_valid_i && !mdu_ready_o) begin
      starve_cnt_next = (starve_cnt_reg == 4'd15) ? 4'd15 : starve_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_reg <= 4'd0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // A granted rd=0 still occupies the slot but never raises the write enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_ena_reg      <= 1'b0;
      w_address_reg  <= 5'd0;
      w_data_reg     <= 32'd0;
      w_from_mdu_reg <= 1'b0;
    end else if (wb_ready_o) begin
      w_ena_reg      <= (wb_rd_i != 5'd0);
      w_address_reg  <= wb_rd_i;
      w_data_reg     <= wb_data_i;
      w_from_mdu_reg <= 1'b0;
    end else if (mdu_ready_o) begin
      w_ena_reg      <= (mdu_rd_i != 5'd0);
      w_address_reg  <= mdu_rd_i;
      w_data_reg     <= mdu_data_i;
      w_from_mdu_reg <= 1'b1;
    end else begin
      w_ena_reg      <= 1'b0;
      w_from_mdu_reg <= 1'b0;
    end
  end

  assign mdu_issue_ready_o = (mdu_issue_rd_i == 5'd0) || !pending_reg[mdu_issue_rd_i];
  assign issue_set         = mdu_issue_i && mdu_issue_ready_o;
  assign mdu_retire        = w_ena_reg && w_from_mdu_reg;

  // Pending bit is cleared on the same edge the register file commits the MDU write.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pending
      if (gi == 0) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_reg
        assign pending_next[gi] = (issue_set && (mdu_issue_rd_i == 5'(gi))) ||
                                  (pending_reg[gi] &&
                                   !(mdu_retire && (w_address_reg == 5'(gi))));
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_reg <= 32'd0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign rs1_busy_o  = (q_rs1_i != 5'd0) && pending_reg[q_rs1_i];
  assign rs2_busy_o  = (q_rs2_i != 5'd0) && pending_reg[q_rs2_i];
  assign rd_busy_o   = (q_rd_i  != 5'd0) && pending_reg[q_rd_i];

  assign w_ena_o     = w_ena_reg;
  assign w_address_o = w_address_reg;
  assign w_data_o    = w_data_reg;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed plus randomized bench for regfile_wr_arbiter against a cycle-level
// behavioural model of grants, write slot and pending destinations.
module tb_regfile_wr_arbiter;

  localparam int STARVE = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_valid_i;
  logic        wb_ready_o;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        mdu_valid_i;
  logic        mdu_ready_o;
  logic [4:0]  mdu_rd_i;
  logic [31:0] mdu_data_i;
  logic        mdu_issue_i;
  logic [4:0]  mdu_issue_rd_i;
  logic        mdu_issue_ready_o;
  logic [4:0]  q_rs1_i;
  logic [4:0]  q_rs2_i;
  logic [4:0]  q_rd_i;
  logic        rs1_busy_o;
  logic        rs2_busy_o;
  logic        rd_busy_o;
  logic        w_ena_o;
  logic [4:0]  w_address_o;
  logic [31:0] w_data_o;

  regfile_wr_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o),
    .mdu_rd_i(mdu_rd_i), .mdu_data_i(mdu_data_i),
    .mdu_issue_i(mdu_issue_i), .mdu_issue_rd_i(mdu_issue_rd_i),
    .mdu_issue_ready_o(mdu_issue_ready_o),
    .q_rs1_i(q_rs1_i), .q_rs2_i(q_rs2_i), .q_rd_i(q_rd_i),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o), .rd_busy_o(rd_busy_o),
    .w_ena_o(w_ena_o), .w_address_o(w_address_o), .w_data_o(w_data_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference state: consecutive MDU denials, set of pending rds, expected write slot.
  int        m_deny;
  bit [31:0] m_pend;
  bit        m_w_ena;
  bit [4:0]  m_w_addr;
  bit [31:0] m_w_data;
  bit        m_w_mdu;
  bit        m_addr_known;
  bit        e_wb, e_mdu, e_iss;

  int        outq[$];
  int        mdu_idx;
  int        hits;

  task automatic chk1(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, want);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic idle();
    rst_i = 1'b0; wb_valid_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
    mdu_valid_i = 1'b0; mdu_rd_i = '0; mdu_data_i = '0;
    mdu_issue_i = 1'b0; mdu_issue_rd_i = '0;
    q_rs1_i = '0; q_rs2_i = '0; q_rd_i = '0;
  endtask

  task automatic model_reset();
    m_deny = 0; m_pend = '0; m_w_ena = 0; m_w_addr = '0; m_w_data = '0;
    m_w_mdu = 0; m_addr_known = 1;
  endtask

  // Inputs are already applied; check the combinational outputs mid-cycle.
  task automatic settle_check();
    bit prio;
    #1;
    prio  = (m_deny >= STARVE);
    e_wb  = wb_valid_i && !(mdu_valid_i && prio);
    e_mdu = mdu_valid_i && !(wb_valid_i && !prio);
    e_iss = (mdu_issue_rd_i == 0) || !m_pend[mdu_issue_rd_i];
    chk1("wb_ready", wb_ready_o, e_wb);
    chk1("mdu_ready", mdu_ready_o, e_mdu);
    chk1("issue_ready", mdu_issue_ready_o, e_iss);
    chk1("rs1_busy", rs1_busy_o, (q_rs1_i != 0) && m_pend[q_rs1_i]);
    chk1("rs2_busy", rs2_busy_o, (q_rs2_i != 0) && m_pend[q_rs2_i]);
    chk1("rd_busy", rd_busy_o, (q_rd_i != 0) && m_pend[q_rd_i]);
  endtask

  // Advance the model through the clock edge and check the registered write port.
  task automatic edge_check();
    if (rst_i) begin
      model_reset();
    end else begin
      if (m_w_ena && m_w_mdu) m_pend[m_w_addr] = 1'b0;
      if (mdu_issue_i && e_iss && mdu_issue_rd_i != 0) m_pend[mdu_issue_rd_i] = 1'b1;
      if (e_wb || e_mdu) begin
        m_w_addr     = e_wb ? wb_rd_i : mdu_rd_i;
        m_w_data     = e_wb ? wb_data_i : mdu_data_i;
        m_w_ena      = (m_w_addr != 0);
        m_w_mdu      = !e_wb;
        m_addr_known = m_w_ena;
      end else begin
        m_w_ena = 0;
        m_w_mdu = 0;
      end
      m_deny = (mdu_valid_i && !e_mdu) ? ((m_deny < 15) ? m_deny + 1 : 15) : 0;
    end
    @(posedge clk_i);
    #1;
    chk1("w_ena", w_ena_o, m_w_ena);
    if (m_addr_known) begin
      chk32("w_address", 32'(w_address_o), 32'(m_w_addr));
      chk32("w_data", w_data_o, m_w_data);
    end
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    chk1("rst_w_ena", w_ena_o, 1'b0);
    chk32("rst_w_address", 32'(w_address_o), 32'd0);
    chk32("rst_w_data", w_data_o, 32'd0);

    // Reset with a pending bit and a live write
    idle(); mdu_issue_i = 1; mdu_issue_rd_i = 5;
    wb_valid_i = 1; wb_rd_i = 9; wb_data_i = 32'h55;
    settle_check(); edge_check();
    chk1("t1_w_ena_live", w_ena_o, 1'b1);
    idle(); rst_i = 1; q_rs1_i = 5;
    settle_check();
    chk1("t1_busy_before", rs1_busy_o, 1'b1);
    edge_check();
    chk1("t1_w_ena_rst", w_ena_o, 1'b0);
    chk32("t1_w_addr_rst", 32'(w_address_o), 32'd0);
    chk32("t1_w_data_rst", w_data_o, 32'd0);
    idle(); q_rs1_i = 5;
    settle_check();
    chk1("t1_busy_after", rs1_busy_o, 1'b0);
    edge_check();

    // Plain WB write
    idle(); wb_valid_i = 1; wb_rd_i = 3; wb_data_i = 32'hDEADBEEF;
    settle_check();
    chk1("t2_wb_ready", wb_ready_o, 1'b1);
    edge_check();
    chk1("t2_w_ena", w_ena_o, 1'b1);
    chk32("t2_w_addr", 32'(w_address_o), 32'd3);
    chk32("t2_w_data", w_data_o, 32'hDEADBEEF);
    idle(); settle_check(); edge_check();
    chk1("t2_w_ena_off", w_ena_o, 1'b0);

    // MDU issue, hazard, result and retire
    idle(); mdu_issue_i = 1; mdu_issue_rd_i = 7; q_rs1_i = 7;
    settle_check();
    chk1("t3_issue_ok", mdu_issue_ready_o, 1'b1);
    chk1("t3_busy0", rs1_busy_o, 1'b0);
    edge_check();
    idle(); mdu_issue_i = 1; mdu_issue_rd_i = 7; q_rs1_i = 7;
    settle_check();
    chk1("t3_issue_block", mdu_issue_ready_o, 1'b0);
    chk1("t3_busy1", rs1_busy_o, 1'b1);
    edge_check();
    idle(); q_rs1_i = 7; mdu_valid_i = 1; mdu_rd_i = 7; mdu_data_i = 42;
    settle_check();
    chk1("t3_mdu_ready", mdu_ready_o, 1'b1);
    edge_check();
    chk1("t3_w_ena", w_ena_o, 1'b1);
    chk32("t3_w_addr", 32'(w_address_o), 32'd7);
    chk32("t3_w_data", w_data_o, 32'd42);
    idle(); q_rs1_i = 7;
    settle_check();
    chk1("t3_busy_n1", rs1_busy_o, 1'b1);
    edge_check();
    idle(); q_rs1_i = 7;
    settle_check();
    chk1("t3_busy_n2", rs1_busy_o, 1'b0);
    edge_check();

    // Starvation: WB wins four times, MDU takes the fifth, then WB again
    for (int i = 0; i < 7; i++) begin
      idle();
      wb_valid_i = (i < 6); wb_rd_i = 5'(10 + i); wb_data_i = 32'(i);
      mdu_valid_i = 1; mdu_rd_i = (i <= 4) ? 5'd11 : 5'd12;
      mdu_data_i = (i <= 4) ? 32'hABCD : 32'hBCDE;
      settle_check();
      chk1($sformatf("t4_wb_ready_%0d", i), wb_ready_o, (i != 4) && (i < 6));
      chk1($sformatf("t4_mdu_ready_%0d", i), mdu_ready_o, (i == 4) || (i == 6));
      edge_check();
    end

    // rd=0 writes and issues
    idle(); wb_valid_i = 1; wb_rd_i = 0; wb_data_i = 32'h1234;
    mdu_issue_i = 1; mdu_issue_rd_i = 0; q_rd_i = 0;
    settle_check();
    chk1("t5_wb_ready", wb_ready_o, 1'b1);
    chk1("t5_issue_ok", mdu_issue_ready_o, 1'b1);
    edge_check();
    chk1("t5_w_ena", w_ena_o, 1'b0);
    idle(); q_rd_i = 0; settle_check();
    chk1("t5_rd_busy", rd_busy_o, 1'b0);
    edge_check();

    // MDU held behind two WB grants, then written exactly once
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      idle();
      wb_valid_i = (i < 2); wb_rd_i = 5'(1 + i); wb_data_i = 32'(100 + i);
      mdu_valid_i = (i < 3); mdu_rd_i = 13; mdu_data_i = 32'hC0FFEE;
      settle_check();
      chk1($sformatf("t6_mdu_ready_%0d", i), mdu_ready_o, (i == 2));
      edge_check();
      if (w_ena_o === 1'b1 && w_address_o === 5'd13 && w_data_o === 32'hC0FFEE) hits++;
    end
    chk32("t6_mdu_writes", 32'(hits), 32'd1);

    // Randomized traffic obeying the valid/ready hold rule
    idle();
    outq.delete();
    for (int n = 0; n < 3000; n++) begin
      rst_i = ($urandom_range(0, 149) == 0);
      if (!wb_valid_i && $urandom_range(0, 2) != 0) begin
        wb_valid_i = 1; wb_rd_i = 5'($urandom); wb_data_i = $urandom;
      end
      if (!mdu_valid_i && outq.size() > 0 && $urandom_range(0, 1) == 1) begin
        mdu_idx = $urandom_range(0, outq.size() - 1);
        mdu_valid_i = 1; mdu_rd_i = 5'(outq[mdu_idx]); mdu_data_i = $urandom;
      end
      mdu_issue_i = $urandom_range(0, 1) == 1;
      mdu_issue_rd_i = 5'($urandom_range(0, 7));
      q_rs1_i = 5'($urandom_range(0, 7));
      q_rs2_i = 5'($urandom_range(0, 7));
      q_rd_i = 5'($urandom_range(0, 7));
      settle_check();
      edge_check();
      if (rst_i) begin
        wb_valid_i = 0; mdu_valid_i = 0; outq.delete();
      end else begin
        if (e_wb) wb_valid_i = 0;
        if (e_mdu) begin
          mdu_valid_i = 0;
          outq.delete(mdu_idx);
        end
        if (mdu_issue_i && e_iss && mdu_issue_rd_i != 0) outq.push_back(int'(mdu_issue_rd_i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Sequences the single write port of the 32x32 register file (1W/2R, x0 hard-wired to zero) between two writers:
  - the in-order WB pipeline stage;
  - the multi-cycle MUL/DIV unit (MDU).
- Keeps a pending-destination scoreboard for MDU results so that decode can stall on RAW/WAW hazards.
- Drives the register file write port from a registered output stage.

Parameters:
- STARVE_MAX, 4: number of consecutive cycles MDU may be denied before it takes priority over WB (range 1..15).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- wb_valid_i  in  1  WB write request
- wb_ready_o  out  1  WB request accepted this cycle
- wb_rd_i  in  5  WB destination
- wb_data_i  in  32  WB data
- mdu_valid_i  in  1  MDU result request
- mdu_ready_o  out  1  MDU result accepted this cycle
- mdu_rd_i  in  5  MDU destination
- mdu_data_i  in  32  MDU result
- mdu_issue_i  in  1  MDU op issue attempt (decode)
- mdu_issue_rd_i  in  5  destination of issued MDU op
- mdu_issue_ready_o  out  1  issue allowed (rd not pending)
- q_rs1_i  in  5  decode rs1 query
- q_rs2_i  in  5  decode rs2 query
- q_rd_i  in  5  decode rd query
- rs1_busy_o  out  1  rs1 pending an MDU write
- rs2_busy_o  out  1  rs2 pending
- rd_busy_o  out  1  rd pending (WAW)
- w_ena_o  out  1  register file write enable (registered)
- w_address_o  out  5  register file write address (registered)
- w_data_o  out  32  register file write data (registered)

Behaviour:
Reset and clocking
- Single clock domain; rst_i is synchronous and active-high.
- Reset values:
  - w_ena_o=0, w_address_o=0, w_data_o=0;
  - starvation counter=0;
  - all 32 pending bits=0.
- rst_i overrides every request in the same cycle. Ready outputs remain combinational during reset, but no acceptance is recorded.

Arbitration (combinational grant)
- Starvation counter (4-bit) increments each cycle that mdu_valid_i=1 and MDU is not granted; it saturates at 15.
- The counter clears when MDU is granted or when mdu_valid_i=0.
- WB has priority, unless the counter is at or above STARVE_MAX, in which case MDU has priority.
- Grant rules:
  - wb_ready_o=1 when wb_valid_i=1 and (MDU not prioritised or mdu_valid_i=0).
  - mdu_ready_o=1 when mdu_valid_i=1 and (wb_valid_i=0 or MDU prioritised).
  - At most one grant per cycle.
- A requester holds valid, rd and data stable until its ready is seen. Dropping valid without ready is illegal.

Write stage
- An accepted request in cycle N produces w_ena_o=1 with the captured rd/data in cycle N+1. The register file commits at the end of N+1.
- No grant in cycle N: w_ena_o=0 in N+1; address and data hold their previous values.
- Accepted rd=0: the request consumes the slot, w_ena_o=0.

Scoreboard
- pending[r] is set at the edge ending the cycle where mdu_issue_i=1, mdu_issue_ready_o=1 and r=mdu_issue_rd_i≠0.
- pending[r] is cleared at the edge ending the cycle where w_ena_o=1, w_address_o=r, and that write originated from MDU.
  - A source flag is registered alongside the write stage to identify MDU-originated writes.
  - The clear coincides with the register file commit, so busy drops from N+2 onward.
- mdu_issue_ready_o = !pending[mdu_issue_rd_i] or mdu_issue_rd_i==0.
  - A clear and a set to the same rd in the same cycle is impossible, because issue is blocked while that rd is pending.
- Busy outputs:
  - rs1_busy_o = pending[q_rs1_i];
  - rs2_busy_o = pending[q_rs2_i];
  - rd_busy_o = pending[q_rd_i];
  - any query of x0 returns 0;
  - all busy outputs are combinational from current state, with no bypass.
- Decode must stall any instruction whose rd_busy_o=1, so WB never overwrites a pending register.
- Reset mid-operation clears all pending bits. The MDU is reset by the same rst_i.

Test Plan:
1. Reset while pending[5]=1 and w_ena_o=1 -> next cycle all outputs 0; rs1_busy_o=0 for q_rs1_i=5.
2. WB valid rd=3 data=0xDEADBEEF in cycle N (no MDU) -> wb_ready_o=1 in N; w_ena_o=1, w_address_o=3, w_data_o=0xDEADBEEF in N+1; w_ena_o=0 in N+2.
3. Issue MDU rd=7, query q_rs1_i=7 -> rs1_busy_o=1 from the next cycle. MDU result rd=7 data=42 accepted in cycle N -> w_ena_o in N+1, rs1_busy_o=0 in N+2. A second issue to rd=7 while pending gives mdu_issue_ready_o=0.
4. WB and MDU both valid continuously (STARVE_MAX=4) -> WB granted 4 cycles, MDU granted on the 5th, counter clears, WB regains priority.
5. WB rd=0 data=0x1234 -> wb_ready_o=1, w_ena_o stays 0. mdu_issue_rd_i=0 -> mdu_issue_ready_o=1, no busy bit set.
6. MDU valid held 2 cycles while WB is granted -> rd/data stable, then accepted. Exactly one write of the MDU value appears on w_*_o.
